ex_muldiv: RTL and testbench

- Execute-stage RV32M unit, directly downstream of the ID/EX pipeline register.
- Decodes the instruction presented by ID/EX and, for MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, latches the operands and runs an iterative radix-2 shift-add multiply or restoring divide.
- Raises a hold request to the pipeline controller while busy, then issues a one-cycle register writeback.
- Non-M instructions, including the flushed-bubble encoding 32'h00000001, are ignored.

---
 rtl/ex_muldiv_pkg.sv | 26 ++
 rtl/ex_muldiv_sign_fix.sv | 30 +++
 rtl/ex_muldiv.sv | 190 +++++++++++++++++++
 tb/tb_ex_muldiv.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared constants and types for the execute-stage RV32M multiply/divide unit.
package ex_muldiv_pkg;

    localparam int          XLEN          = 32;
    localparam int          ITER          = 32;
    localparam logic [31:0] NOP_INST      = 32'h00000001;

    localparam logic [6:0]  OPCODE_OP     = 7'b0110011;
    localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0]  F3_MUL        = 3'b000;
    localparam logic [2:0]  F3_MULH       = 3'b001;
    localparam logic [2:0]  F3_MULHSU     = 3'b010;
    localparam logic [2:0]  F3_MULHU      = 3'b011;
    localparam logic [2:0]  F3_DIV        = 3'b100;
    localparam logic [2:0]  F3_DIVU       = 3'b101;
    localparam logic [2:0]  F3_REM        = 3'b110;
    localparam logic [2:0]  F3_REMU       = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ex_muldiv_sign_fix.sv
// Conditional two's-complement negation of two lanes, or of both lanes joined
// as one double-width value when wide_i is set (a_neg_i controls that case).
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         a_neg_i,
    input  logic         b_neg_i,
    input  logic         wide_i,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o
);

    logic [2*W-1:0] wide_s;

    assign wide_s = a_neg_i ? -{a_i, b_i} : {a_i, b_i};

    // Select joined or per-lane negation.
    always_comb begin
        if (wide_i) begin
            a_o = wide_s[2*W-1:W];
            b_o = wide_s[W-1:0];
        end else begin
            a_o = a_neg_i ? -a_i : a_i;
            b_o = b_neg_i ? -b_i : b_i;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M execute unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, with a one-cycle registered writeback.
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic        flush_i,
    output logic        hold_req_o,
    output logic        busy_o,
    output logic        rd_we_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o
);

    localparam logic [4:0] LAST_CNT = 5'(ITER - 1);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;
    logic        neg_q, neg_d;
    logic        busy_q, busy_d;
    logic        rd_we_q, rd_we_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rd_data_q, rd_data_d;

    logic [2:0]  f3_s;
    logic        start_s, s1_signed_s, s2_signed_s, a_neg_s, b_neg_s, neg_flag_s;
    logic        div_zero_s, ovf_s, special_s;
    logic [31:0] special_res_s, a_mag_s, b_mag_s;
    logic [32:0] mul_sum_s, div_shift_s, div_diff_s;
    logic [63:0] mul_next_s, div_next_s, acc_step_s;
    logic [31:0] fix_hi_s, fix_lo_s, calc_res_s;

    assign f3_s    = inst_i[14:12];
    assign start_s = (state_q == IDLE) && !flush_i && (inst_i != NOP_INST)
                     && (inst_i[6:0] == OPCODE_OP) && (inst_i[31:25] == FUNCT7_MULDIV)
                     && (rd_addr_i != 5'd0);

    assign s1_signed_s = (f3_s == F3_MULH) || (f3_s == F3_MULHSU)
                         || (f3_s == F3_DIV) || (f3_s == F3_REM);
    assign s2_signed_s = (f3_s == F3_MULH) || (f3_s == F3_DIV) || (f3_s == F3_REM);
    assign a_neg_s     = rs1_data_i[31] & s1_signed_s;
    assign b_neg_s     = rs2_data_i[31] & s2_signed_s;
    // Remainder follows the dividend; products and quotients follow the sign product.
    assign neg_flag_s  = (f3_s == F3_REM) ? a_neg_s : (a_neg_s ^ b_neg_s);

    assign div_zero_s  = f3_s[2] && (rs2_data_i == 32'd0);
    assign ovf_s       = f3_s[2] && !f3_s[0] && (rs1_data_i == 32'h80000000)
                         && (rs2_data_i == 32'hFFFFFFFF);
    assign special_s   = div_zero_s || ovf_s;
    assign special_res_s = div_zero_s ? (f3_s[1] ? rs1_data_i : 32'hFFFFFFFF)
                                      : (f3_s[1] ? 32'd0 : 32'h80000000);

    muldiv_sign_fix #(.W(32)) u_prep (
        .a_i     (rs1_data_i),
        .b_i     (rs2_data_i),
        .a_neg_i (a_neg_s),
        .b_neg_i (b_neg_s),
        .wide_i  (1'b0),
        .a_o     (a_mag_s),
        .b_o     (b_mag_s)
    );

    // acc holds {product-high | remainder, multiplier | quotient}.
    assign mul_sum_s   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    assign mul_next_s  = {mul_sum_s, acc_q[31:1]};
    assign div_shift_s = {acc_q[63:32], acc_q[31]};
    assign div_diff_s  = div_shift_s - {1'b0, b_q};
    assign div_next_s  = div_diff_s[32] ? {div_shift_s[31:0], acc_q[30:0], 1'b0}
                                        : {div_diff_s[31:0], acc_q[30:0], 1'b1};
    assign acc_step_s  = f3_q[2] ? div_next_s : mul_next_s;

    muldiv_sign_fix #(.W(32)) u_fix (
        .a_i     (acc_step_s[63:32]),
        .b_i     (acc_step_s[31:0]),
        .a_neg_i (neg_q),
        .b_neg_i (neg_q),
        .wide_i  (!f3_q[2]),
        .a_o     (fix_hi_s),
        .b_o     (fix_lo_s)
    );

    assign calc_res_s = (f3_q == F3_MUL) ? fix_lo_s
                      : (f3_q[2] ? (f3_q[1] ? fix_hi_s : fix_lo_s) : fix_hi_s);

    // Next-state, datapath and writeback computation; flush overrides everything.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_d       = b_q;
        f3_d      = f3_q;
        rd_d      = rd_q;
        neg_d     = neg_q;
        rd_we_d   = 1'b0;
        rd_addr_d = 5'd0;
        rd_data_d = 32'd0;
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    f3_d  = f3_s;
                    rd_d  = rd_addr_i;
                    neg_d = neg_flag_s;
                    cnt_d = 5'd0;
                    if (special_s) begin
                        state_d   = DONE;
                        rd_we_d   = 1'b1;
                        rd_addr_d = rd_addr_i;
                        rd_data_d = special_res_s;
                    end else begin
                        state_d = CALC;
                        acc_d   = {32'd0, a_mag_s};
                        b_d     = b_mag_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                acc_d = acc_step_s;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d   = DONE;
                    cnt_d     = 5'd0;
                    rd_we_d   = 1'b1;
                    rd_addr_d = rd_q;
                    rd_data_d = calc_res_s;
                end else begin
                    state_d = CALC;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d   = IDLE;
            cnt_d     = 5'd0;
            rd_we_d   = 1'b0;
            rd_addr_d = 5'd0;
            rd_data_d = 32'd0;
        end else begin
            cnt_d = cnt_d;
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            acc_q     <= 64'd0;
            b_q       <= 32'd0;
            f3_q      <= 3'd0;
            rd_q      <= 5'd0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            rd_we_q   <= 1'b0;
            rd_addr_q <= 5'd0;
            rd_data_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            f3_q      <= f3_d;
            rd_q      <= rd_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            rd_we_q   <= rd_we_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign hold_req_o = start_s || (state_q == CALC);
    assign busy_o     = busy_q;
    assign rd_we_o    = rd_we_q & !flush_i;
    assign rd_addr_o  = rd_addr_q;
    assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: expected writebacks (cycle, rd, data) are
// queued at issue and matched against every observed rd_we_o strobe.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        flush_i;
    logic        hold_req_o;
    logic        busy_o;
    logic        rd_we_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic mon_en = 1'b0;

    ex_muldiv dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst_i     (inst_i),
        .rd_addr_i  (rd_addr_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .flush_i    (flush_i),
        .hold_req_o (hold_req_o),
        .busy_o     (busy_o),
        .rd_we_o    (rd_we_o),
        .rd_addr_o  (rd_addr_o),
        .rd_data_o  (rd_data_o)
    );

    always #5 clk = ~clk;

    // Cycle index used to time-stamp expected writebacks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [4:0] rd);
        return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] p;
        logic               ovf;
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (f3)
            3'd0: return a * b;
            3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
            3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return p[63:32]; end
            3'd3: begin p = $signed({32'd0, a} * {32'd0, b}); return p[63:32]; end
            3'd4: return (b == 32'd0) ? 32'hFFFFFFFF : ovf ? 32'h80000000 : 32'($signed(a) / $signed(b));
            3'd5: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
            3'd6: return (b == 32'd0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Scoreboard monitor: every strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_we_o) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_we", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("wb_cycle", cyc, e.cyc);
                    chk("wb_addr", {27'd0, rd_addr_o}, {27'd0, e.rd});
                    chk("wb_data", rd_data_o, e.data);
                end
            end else if (!flush_i) begin
                chk("quiet_out", {27'd0, rd_addr_o} | rd_data_o, 32'd0);
            end
        end
    end

    // Presents one instruction for one cycle (caller is just after a posedge).
    task automatic issue(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a,
                         input logic [31:0] b, input logic expect_wb, input int lat,
                         input logic [31:0] exp);
        exp_t e;
        inst_i     = mk_inst(f3, rd);
        rd_addr_i  = rd;
        rs1_data_i = a;
        rs2_data_i = b;
        if (expect_wb) begin
            e.cyc  = cyc + lat;
            e.rd   = rd;
            e.data = exp;
            sb_q.push_back(e);
        end
        @(negedge clk);
        chk("hold_t0", {31'd0, hold_req_o}, 32'd1);
        @(posedge clk); #1;
        inst_i     = 32'h00000001;
        rd_addr_i  = 5'd0;
        rs1_data_i = 32'd0;
        rs2_data_i = 32'd0;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 45 && !done; i++) begin
            @(negedge clk);
            if (!busy_o) done = 1'b1;
        end
        if (!done) chk("idle_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic        spec;
        rst_n = 1'b0; flush_i = 1'b0; inst_i = 32'h00000001;
        rd_addr_i = 5'd0; rs1_data_i = 32'd0; rs2_data_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_we", {31'd0, rd_we_o}, 32'd0);
        chk("rst_out", {27'd0, rd_addr_o} | rd_data_o, 32'd0);
        chk("rst_hold", {31'd0, hold_req_o}, 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // MUL with hold profile T1..T33
        issue(3'd0, 5'd5, 32'd7, 32'hFFFFFFFD, 1'b1, 33, 32'hFFFFFFEB);
        for (int t = 1; t <= 33; t++) begin
            @(negedge clk);
            chk("hold_calc", {31'd0, hold_req_o}, (t <= 32) ? 32'd1 : 32'd0);
            chk("busy_calc", {31'd0, busy_o}, 32'd1);
        end
        wait_idle();

        issue(3'd1, 5'd6, 32'h80000000, 32'h80000000, 1'b1, 33, 32'h40000000); wait_idle();
        issue(3'd3, 5'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33, 32'hFFFFFFFE); wait_idle();
        issue(3'd2, 5'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33, 32'hFFFFFFFF); wait_idle();
        issue(3'd4, 5'd9, 32'hFFFFFFF9, 32'd2, 1'b1, 33, 32'hFFFFFFFD); wait_idle();
        issue(3'd6, 5'd10, 32'hFFFFFFF9, 32'd2, 1'b1, 33, 32'hFFFFFFFF); wait_idle();
        issue(3'd5, 5'd11, 32'd100, 32'd7, 1'b1, 33, 32'd14); wait_idle();
        issue(3'd7, 5'd12, 32'd100, 32'd7, 1'b1, 33, 32'd2); wait_idle();
        issue(3'd5, 5'd13, 32'd123, 32'd0, 1'b1, 1, 32'hFFFFFFFF); wait_idle();
        issue(3'd6, 5'd14, 32'd123, 32'd0, 1'b1, 1, 32'd123); wait_idle();
        issue(3'd4, 5'd15, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1, 32'h80000000); wait_idle();
        issue(3'd6, 5'd16, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1, 32'd0); wait_idle();

        // Modelled mix of operations and operand signs
        for (int i = 0; i < 16; i++) begin
            f3 = 3'(i % 8);
            a  = $urandom();
            b  = (i % 3 == 0) ? $urandom_range(1, 300) : $urandom();
            if (i % 5 == 1) a = -a;
            spec = f3[2] && ((b == 32'd0) || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
            issue(f3, 5'(17 + (i % 14)), a, b, 1'b1, spec ? 1 : 33, ref_res(f3, a, b));
            wait_idle();
        end

        // Flush at T10; a second M op at T5 must be ignored
        issue(3'd4, 5'd20, 32'd1000, 32'd3, 1'b0, 0, 32'd0);
        repeat (4) begin @(posedge clk); #1; end
        inst_i = mk_inst(3'd0, 5'd21); rd_addr_i = 5'd21; rs1_data_i = 32'd3; rs2_data_i = 32'd4;
        @(posedge clk); #1;
        inst_i = 32'h00000001; rd_addr_i = 5'd0; rs1_data_i = 32'd0; rs2_data_i = 32'd0;
        repeat (4) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_busy", {31'd0, busy_o}, 32'd0);
        repeat (40) @(posedge clk);
        #1;

        // rd==x0 and bubble are never accepted
        inst_i = mk_inst(3'd0, 5'd0); rd_addr_i = 5'd0; rs1_data_i = 32'd5; rs2_data_i = 32'd6;
        @(negedge clk);
        chk("x0_hold", {31'd0, hold_req_o}, 32'd0);
        @(negedge clk);
        chk("x0_busy", {31'd0, busy_o}, 32'd0);
        inst_i = 32'h00000001; rd_addr_i = 5'd3;
        @(negedge clk);
        chk("nop_hold", {31'd0, hold_req_o}, 32'd0);
        @(negedge clk);
        chk("nop_busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk); #1;
        rd_addr_i = 5'd0;

        // Reset at T15 of a DIV
        issue(3'd4, 5'd22, 32'd5000, 32'd7, 1'b0, 0, 32'd0);
        repeat (14) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        chk("midrst_hold", {31'd0, hold_req_o}, 32'd0);
        chk("midrst_we", {31'd0, rd_we_o}, 32'd0);
        chk("midrst_out", {27'd0, rd_addr_o} | rd_data_o, 32'd0);
        repeat (40) @(posedge clk);
        #1;

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
